asi_arb: RTL and testbench

//  Burst-level arbiter for the single-port user memory shared by the ASI read and write paths.

---
 rtl/asi_pkg.sv | 17 +
 rtl/asi_arb.sv | 118 +++++++++++
 tb/tb_asi_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/asi_pkg.sv
// Shared ASI definitions: arbiter state encoding and burst constants used by
// asi_r, asi_w and asi_arb.
package asi_pkg;

  // Arbiter ownership states of the single-port user memory
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_st_e;

  // Burst geometry shared by the read and write paths
  localparam int BT_LEN_W     = 8;
  localparam int BT_MAX_BEATS = 1 << BT_LEN_W;
  localparam int BT_SINGLE    = 1;

endpackage

// File: rtl/asi_arb.sv
// asi_arb: burst-level arbiter for the user memory shared by the ASI read and
// write paths. Fixed priority (ASI_ARB) with an anti-starvation limit
// (ARB_MAXG consecutive priority bursts while the other side waits).
// Optional macro ASI_ARB_STAT_EN adds saturating completed-burst counters.
//
// Handshake: a requester holds usr_*request high while it has a burst pending.
// Once usr_*grant is seen high it issues beats with usr_re/usr_we; the burst
// ends on the beat where usr_*last is also high, and the grant is released (or
// handed over) on the following clock edge. Beats without grant are ignored.
module asi_arb
  import asi_pkg::*;
#(
  parameter int ASI_ARB  = 0,
  parameter int ARB_MAXG = 4
`ifdef ASI_ARB_STAT_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic    usr_clk,
  input  logic    usr_reset,
  input  logic    usr_rrequest,
  input  logic    usr_re,
  input  logic    usr_rlast,
  output logic    usr_rgrant,
  input  logic    usr_wrequest,
  input  logic    usr_we,
  input  logic    usr_wlast,
  output logic    usr_wgrant,
  output logic    arb_busy,
  output arb_st_e arb_state
`ifdef ASI_ARB_STAT_EN
  , output logic [STAT_W-1:0] stat_rbursts
  , output logic [STAT_W-1:0] stat_wbursts
`endif
);

  localparam int CNT_W = (ARB_MAXG < 1) ? 1 : $clog2(ARB_MAXG + 1);
  localparam logic [CNT_W-1:0] MAXG_C = CNT_W'(ARB_MAXG);
  localparam arb_st_e PRI_ST = (ASI_ARB != 0) ? ARB_RD : ARB_WR;
  localparam arb_st_e OTH_ST = (ASI_ARB != 0) ? ARB_WR : ARB_RD;

  arb_st_e          state;
  arb_st_e          state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_eff;
  logic [CNT_W-1:0] starve_nxt;
  logic             rdone;
  logic             wdone;
  logic             pri_done;
  logic             oth_req;

  // Choose the next owner from the current requests; force the waiting side
  // once the priority side has used up its consecutive-burst allowance.
  function automatic arb_st_e pick(input logic rreq, input logic wreq,
                                   input logic starved);
    arb_st_e s;
    if (rreq && wreq)  s = starved ? OTH_ST : PRI_ST;
    else if (rreq)     s = ARB_RD;
    else if (wreq)     s = ARB_WR;
    else               s = ARB_IDLE;
    return s;
  endfunction

  // Next-state and starvation bookkeeping; the count used for a decision
  // already includes the priority burst that is finishing this cycle.
  always_comb begin
    rdone    = (state == ARB_RD) && usr_re && usr_rlast;
    wdone    = (state == ARB_WR) && usr_we && usr_wlast;
    pri_done = (ASI_ARB != 0) ? rdone : wdone;
    oth_req  = (ASI_ARB != 0) ? usr_wrequest : usr_rrequest;

    starve_eff = starve_cnt;
    if (pri_done && oth_req && (starve_cnt != MAXG_C))
      starve_eff = starve_cnt + 1'b1;

    state_nxt = state;
    if ((state == ARB_IDLE) || rdone || wdone)
      state_nxt = pick(usr_rrequest, usr_wrequest,
                       (ARB_MAXG != 0) && (starve_eff == MAXG_C));

    starve_nxt = starve_eff;
    if (!oth_req || (state_nxt == OTH_ST))
      starve_nxt = '0;
  end

  // Arbiter FSM with grants registered alongside the state
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      usr_rgrant <= 1'b0;
      usr_wgrant <= 1'b0;
      arb_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      usr_rgrant <= (state_nxt == ARB_RD);
      usr_wgrant <= (state_nxt == ARB_WR);
      arb_busy   <= (state_nxt != ARB_IDLE);
    end
  end

  assign arb_state = state;

`ifdef ASI_ARB_STAT_EN
  // Saturating counts of completed read and write bursts
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      stat_rbursts <= '0;
      stat_wbursts <= '0;
    end else begin
      if (rdone && (stat_rbursts != '1)) stat_rbursts <= stat_rbursts + 1'b1;
      if (wdone && (stat_wbursts != '1)) stat_wbursts <= stat_wbursts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: three instances with different priority / starvation
// settings share one clock and reset, each driven by its own requester model
// and compared every cycle against a behavioural ownership model.
module tb_asi_arb;
  import asi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic    rreq[3], re[3], rlast[3], wreq[3], we[3], wlast[3];
  logic    rg[3], wg[3], busy[3];
  arb_st_e st[3];
`ifdef ASI_ARB_STAT_EN
  logic [1:0] srb[3], swb[3];
`endif

  asi_arb #(.ASI_ARB(0), .ARB_MAXG(4)
`ifdef ASI_ARB_STAT_EN
    , .STAT_W(2)
`endif
  ) dut0 (
    .usr_clk(clk), .usr_reset(rst),
    .usr_rrequest(rreq[0]), .usr_re(re[0]), .usr_rlast(rlast[0]), .usr_rgrant(rg[0]),
    .usr_wrequest(wreq[0]), .usr_we(we[0]), .usr_wlast(wlast[0]), .usr_wgrant(wg[0]),
    .arb_busy(busy[0]), .arb_state(st[0])
`ifdef ASI_ARB_STAT_EN
    , .stat_rbursts(srb[0]), .stat_wbursts(swb[0])
`endif
  );

  asi_arb #(.ASI_ARB(1), .ARB_MAXG(2)
`ifdef ASI_ARB_STAT_EN
    , .STAT_W(2)
`endif
  ) dut1 (
    .usr_clk(clk), .usr_reset(rst),
    .usr_rrequest(rreq[1]), .usr_re(re[1]), .usr_rlast(rlast[1]), .usr_rgrant(rg[1]),
    .usr_wrequest(wreq[1]), .usr_we(we[1]), .usr_wlast(wlast[1]), .usr_wgrant(wg[1]),
    .arb_busy(busy[1]), .arb_state(st[1])
`ifdef ASI_ARB_STAT_EN
    , .stat_rbursts(srb[1]), .stat_wbursts(swb[1])
`endif
  );

  asi_arb #(.ASI_ARB(0), .ARB_MAXG(0)
`ifdef ASI_ARB_STAT_EN
    , .STAT_W(2)
`endif
  ) dut2 (
    .usr_clk(clk), .usr_reset(rst),
    .usr_rrequest(rreq[2]), .usr_re(re[2]), .usr_rlast(rlast[2]), .usr_rgrant(rg[2]),
    .usr_wrequest(wreq[2]), .usr_we(we[2]), .usr_wlast(wlast[2]), .usr_wgrant(wg[2]),
    .arb_busy(busy[2]), .arb_state(st[2])
`ifdef ASI_ARB_STAT_EN
    , .stat_rbursts(srb[2]), .stat_wbursts(swb[2])
`endif
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = read side, 2 = write side
  int m_own[3], m_run[3], m_rb[3], m_wb[3];

  function automatic int pri_of(input int k);   // side with priority
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic int maxg_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_own[k] = 0; m_run[k] = 0; m_rb[k] = 0; m_wb[k] = 0;
    end
  endtask

  // What the arbiter should do at the coming clock edge given the inputs now applied
  task automatic model_step(input int k);
    int  p, o, nxt;
    bit  rd, wd, want_r, want_w, other_wants;
    p  = pri_of(k);
    o  = 3 - p;
    rd = (m_own[k] == 1) && re[k] && rlast[k];
    wd = (m_own[k] == 2) && we[k] && wlast[k];
    want_r = rreq[k];
    want_w = wreq[k];
    other_wants = (o == 1) ? want_r : want_w;
    if (rd) m_rb[k]++;
    if (wd) m_wb[k]++;
    if ((rd || wd) && m_own[k] == p && other_wants) m_run[k]++;
    nxt = m_own[k];
    if (m_own[k] == 0 || rd || wd) begin
      if (want_r && want_w)
        nxt = (maxg_of(k) != 0 && m_run[k] >= maxg_of(k)) ? o : p;
      else if (want_r) nxt = 1;
      else if (want_w) nxt = 2;
      else             nxt = 0;
    end
    if (!other_wants || nxt == o) m_run[k] = 0;
    m_own[k] = nxt;
  endtask

  task automatic check_outputs(input int k);
    arb_st_e exp_st;
    exp_st = (m_own[k] == 1) ? ARB_RD : (m_own[k] == 2) ? ARB_WR : ARB_IDLE;
    chk($sformatf("d%0d_rgrant", k), 32'(rg[k]), 32'(m_own[k] == 1));
    chk($sformatf("d%0d_wgrant", k), 32'(wg[k]), 32'(m_own[k] == 2));
    chk($sformatf("d%0d_busy", k),   32'(busy[k]), 32'(m_own[k] != 0));
    chk($sformatf("d%0d_state", k),  32'(st[k]), 32'(exp_st));
    chk($sformatf("d%0d_excl", k),   32'(rg[k] & wg[k]), 32'd0);
`ifdef ASI_ARB_STAT_EN
    chk($sformatf("d%0d_stat_r", k), 32'(srb[k]), (m_rb[k] > 3) ? 32'd3 : 32'(m_rb[k]));
    chk($sformatf("d%0d_stat_w", k), 32'(swb[k]), (m_wb[k] > 3) ? 32'd3 : 32'(m_wb[k]));
`endif
  endtask

  // ---------------- drivers ----------------
  // mode 0: random traffic; 1: both request, single-beat bursts;
  // 2: write-only long burst (never last); 3: read-only single-beat bursts
  task automatic drive(input int k, input int mode);
    case (mode)
      1: begin
        rreq[k] = 1'b1; wreq[k] = 1'b1;
        re[k] = (m_own[k] == 1); rlast[k] = (m_own[k] == 1);
        we[k] = (m_own[k] == 2); wlast[k] = (m_own[k] == 2);
      end
      2: begin
        rreq[k] = 1'b0; wreq[k] = 1'b1;
        re[k] = 1'b0; rlast[k] = 1'b0;
        we[k] = (m_own[k] == 2); wlast[k] = 1'b0;
      end
      3: begin
        rreq[k] = 1'b1; wreq[k] = 1'b0;
        re[k] = (m_own[k] == 1); rlast[k] = (m_own[k] == 1);
        we[k] = 1'b0; wlast[k] = 1'b0;
      end
      default: begin
        rreq[k]  = ($urandom_range(0, 3) != 0);
        wreq[k]  = ($urandom_range(0, 3) != 0);
        re[k]    = (m_own[k] == 1) && ($urandom_range(0, 3) != 0);
        rlast[k] = ($urandom_range(0, 2) == 0);
        we[k]    = (m_own[k] == 2) && ($urandom_range(0, 3) != 0);
        wlast[k] = ($urandom_range(0, 2) == 0);
      end
    endcase
  endtask

  task automatic zero_inputs();
    for (int k = 0; k < 3; k++) begin
      rreq[k] = 1'b0; re[k] = 1'b0; rlast[k] = 1'b0;
      wreq[k] = 1'b0; we[k] = 1'b0; wlast[k] = 1'b0;
    end
  endtask

  task automatic step(input int mode);
    for (int k = 0; k < 3; k++) begin
      drive(k, mode);
      model_step(k);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_outputs(k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_outputs(k);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  string ord[3];
  string exp_ord[3];

  initial begin
    rst = 1'b1;
    zero_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_outputs(k);
    rst = 1'b0;

    // Both sides always requesting with single-beat bursts: grant order
    exp_ord[0] = "WWWWRW";
    exp_ord[1] = "RRWRRW";
    exp_ord[2] = "WWWWWW";
    for (int k = 0; k < 3; k++) ord[k] = "";
    for (int i = 0; i < 6; i++) begin
      step(1);
      for (int k = 0; k < 3; k++)
        ord[k] = {ord[k], rg[k] ? "R" : (wg[k] ? "W" : "-")};
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 6; i++)
        chk($sformatf("d%0d_order%0d", k, i), 32'(ord[k][i]), 32'(exp_ord[k][i]));

    // Five back-to-back single-beat read bursts
    do_reset();
    for (int i = 0; i < 6; i++) step(3);
`ifdef ASI_ARB_STAT_EN
    chk("stat_r_saturated", 32'(srb[1]), 32'd3);
    chk("stat_w_zero", 32'(swb[1]), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) step(0);

    // Reset in the middle of a long write burst
    do_reset();
    for (int i = 0; i < 3; i++) step(2);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_rst_wgrant", k), 32'(wg[k]), 32'd0);
      chk($sformatf("d%0d_rst_rgrant", k), 32'(rg[k]), 32'd0);
      chk($sformatf("d%0d_rst_busy", k),   32'(busy[k]), 32'd0);
      chk($sformatf("d%0d_rst_state", k),  32'(st[k]), 32'(ARB_IDLE));
    end
    zero_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Normal operation resumes
    for (int i = 0; i < 300; i++) step(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
